// File: rtl/yas_router_pkg.sv
// Shared router definitions: data width, channel count, FIFO depth.
// Pointer type is reused by the channel output logic.
package yas_router_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int NUM_CH      = 3;
    localparam int FIFO_ADDR_W = 5;
    localparam int PTR_W       = FIFO_ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/pkt_fifo_mem.sv
// Packet FIFO storage: DEPTH x DATA_WIDTH register array.
// Ports: clk; we/waddr/wdata write port; raddr/rdata async read port.
module pkt_fifo_mem
    import yas_router_pkg::*;
#(
    parameter int DW = yas_router_pkg::DATA_WIDTH,
    parameter int AW = yas_router_pkg::FIFO_ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Per-channel packet FIFO with speculative write, commit and flush.
// Ports: clk, rst_n; push/flush/wr_ptr_upd/data_in/full write side;
// rd_pop/rd_valid/rd_data/level read side; ovf_err sticky overflow.
module pkt_fifo #(
    parameter int DATA_WIDTH = yas_router_pkg::DATA_WIDTH,
    parameter int ADDR_W     = yas_router_pkg::FIFO_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  flush,
    input  logic                  wr_ptr_upd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  rd_pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_W:0]       level,
    output logic                  ovf_err
);

    import yas_router_pkg::*;

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         cmt_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_next;
    logic [PW-1:0]         wr_used;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Occupancy counts speculative bytes too, so full uses wr_ptr.
    assign wr_used  = wr_ptr - rd_ptr;
    assign full     = (wr_used == FULL_CNT);
    assign rd_valid = (cmt_ptr != rd_ptr);
    assign level    = cmt_ptr - rd_ptr;
    assign rd_data  = rd_valid ? mem_rdata : '0;

    assign push_ok  = push && !full && !flush;
    assign pop_ok   = rd_pop && rd_valid;
    // A commit includes a byte pushed on the same edge.
    assign wr_next  = wr_ptr + PW'(push_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= cmt_ptr;
            end else begin
                wr_ptr <= wr_next;
            end
            if (wr_ptr_upd && !flush) begin
                cmt_ptr <= wr_next;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    pkt_fifo_mem #(
        .DW (DATA_WIDTH),
        .AW (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule
